nibble_mem_responder: RTL and testbench

//  Memory-side responder for the 4-bit processor's load/store path. Accepts nibble-serial

---
 rtl/nibble_mem_responder_pkg.sv | 25 ++
 rtl/nibble_mem_array.sv | 26 ++
 rtl/nibble_mem_responder.sv | 139 +++++++++++++
 tb/tb_nibble_mem_responder.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nibble_mem_responder_pkg.sv
// Shared definitions for the nibble-serial memory responder: widths, wait-state limit
// and the FSM state encoding also used by the processor side.
package nibble_mem_responder_pkg;

    localparam int ADDR_W   = 8;
    localparam int DATA_W   = 8;
    localparam int MAX_WAIT = 15;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ADDR_LO = 3'd1,
        ST_DATA_HI = 3'd2,
        ST_DATA_LO = 3'd3,
        ST_ACCESS  = 3'd4,
        ST_WDONE   = 3'd5,
        ST_RSP_HI  = 3'd6,
        ST_RSP_LO  = 3'd7
    } state_t;

    // States in which a request nibble can be taken from the processor.
    function automatic logic takes_request(input state_t s);
        return (s == ST_IDLE) || (s == ST_ADDR_LO) || (s == ST_DATA_HI) || (s == ST_DATA_LO);
    endfunction

endpackage

// File: rtl/nibble_mem_array.sv
// 256 x 8 storage with one synchronous write port and one registered read port.
// Contents are deliberately not reset.
module nibble_mem_array
    import nibble_mem_responder_pkg::*;
(
    input  logic              clk,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic [DATA_W-1:0] rd_data_o
);

    logic [DATA_W-1:0] mem_q [2**ADDR_W];
    logic [DATA_W-1:0] rd_data_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
        rd_data_q <= mem_q[rd_addr_i];
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/nibble_mem_responder.sv
// Memory-side responder: collects nibble-serial load/store requests, services them from
// nibble_mem_array after WAIT_STATES extra cycles, and returns read data nibble-serially.
module nibble_mem_responder
    import nibble_mem_responder_pkg::*;
#(
    parameter int WAIT_STATES = 1,
    parameter int NIB_W       = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_we,
    input  logic [NIB_W-1:0] req_nib,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [NIB_W-1:0] rsp_nib,
    output logic             wr_done,
    output logic             busy
);

    localparam logic [3:0] WAIT_LD = (WAIT_STATES > MAX_WAIT) ? 4'(MAX_WAIT) : 4'(WAIT_STATES);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rd_buf_q, rd_buf_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              we_q, we_d;
    logic [DATA_W-1:0] rd_data;
    logic              req_fire, rsp_fire, access_last, mem_we;

    assign req_fire    = req_valid && req_ready;
    assign rsp_fire    = rsp_valid && rsp_ready;
    assign access_last = (state_q == ST_ACCESS) && (cnt_q == 4'd0);
    // A reset landing on the final access cycle must not commit the write.
    assign mem_we      = access_last && we_q && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            addr_q   <= '0;
            wdata_q  <= '0;
            rd_buf_q <= '0;
            cnt_q    <= '0;
            we_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rd_buf_q <= rd_buf_d;
            cnt_q    <= cnt_d;
            we_q     <= we_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (req_fire) state_d = ST_ADDR_LO;
            ST_ADDR_LO: if (req_fire) state_d = we_q ? ST_DATA_HI : ST_ACCESS;
            ST_DATA_HI: if (req_fire) state_d = ST_DATA_LO;
            ST_DATA_LO: if (req_fire) state_d = ST_ACCESS;
            ST_ACCESS:  if (cnt_q == 4'd0) state_d = we_q ? ST_WDONE : ST_RSP_HI;
            ST_WDONE:   state_d = ST_IDLE;
            ST_RSP_HI:  if (rsp_fire) state_d = ST_RSP_LO;
            ST_RSP_LO:  if (rsp_fire) state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rd_buf_d = rd_buf_q;
        cnt_d    = cnt_q;
        we_d     = we_q;
        case (state_q)
            ST_IDLE: begin
                if (req_fire) begin
                    addr_d[7:4] = req_nib;
                    we_d        = req_we;
                end
            end
            ST_ADDR_LO: begin
                if (req_fire) begin
                    addr_d[3:0] = req_nib;
                    cnt_d       = WAIT_LD;
                end
            end
            ST_DATA_HI: if (req_fire) wdata_d[7:4] = req_nib;
            ST_DATA_LO: begin
                if (req_fire) begin
                    wdata_d[3:0] = req_nib;
                    cnt_d        = WAIT_LD;
                end
            end
            ST_ACCESS: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else if (!we_q) begin
                    rd_buf_d = rd_data;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        req_ready = takes_request(state_q);
        busy      = (state_q != ST_IDLE);
        wr_done   = (state_q == ST_WDONE);
        rsp_valid = 1'b0;
        rsp_nib   = '0;
        case (state_q)
            ST_RSP_HI: begin
                rsp_valid = 1'b1;
                rsp_nib   = rd_buf_q[7:4];
            end
            ST_RSP_LO: begin
                rsp_valid = 1'b1;
                rsp_nib   = rd_buf_q[3:0];
            end
            default: ;
        endcase
    end

    // Read address follows the next-state address so the registered read port already
    // holds mem[addr] during the first access cycle, even with zero wait states.
    nibble_mem_array u_array (
        .clk       (clk),
        .we_i      (mem_we),
        .wr_addr_i (addr_q),
        .wr_data_i (wdata_q),
        .rd_addr_i (addr_d),
        .rd_data_o (rd_data)
    );

endmodule

// File: tb/tb_nibble_mem_responder.sv
// Directed bench: dut1 is built with one wait state, dut0 with none. Latencies are counted
// in clock edges after the beat's own edge (the beat edge itself is edge 1 of WAIT_STATES+2).
module tb_nibble_mem_responder;

    logic       clk;
    logic       rst;
    logic [1:0] req_valid;
    logic [1:0] req_ready;
    logic       req_we;
    logic [3:0] req_nib;
    logic [1:0] rsp_valid;
    logic [1:0] rsp_ready;
    logic [3:0] rsp_nib0, rsp_nib1;
    logic [1:0] wr_done;
    logic [1:0] busy;

    int tests = 0;
    int fails = 0;

    nibble_mem_responder #(.WAIT_STATES(0), .NIB_W(4)) u_dut0 (
        .clk(clk), .rst(rst), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_we(req_we), .req_nib(req_nib), .rsp_valid(rsp_valid[0]),
        .rsp_ready(rsp_ready[0]), .rsp_nib(rsp_nib0), .wr_done(wr_done[0]), .busy(busy[0])
    );

    nibble_mem_responder #(.WAIT_STATES(1), .NIB_W(4)) u_dut1 (
        .clk(clk), .rst(rst), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_we(req_we), .req_nib(req_nib), .rsp_valid(rsp_valid[1]),
        .rsp_ready(rsp_ready[1]), .rsp_nib(rsp_nib1), .wr_done(wr_done[1]), .busy(busy[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time exceeded, required completion");
        $fatal(1, "watchdog");
    end

    function automatic logic [3:0] nib_of(input int d);
        return (d != 0) ? rsp_nib1 : rsp_nib0;
    endfunction

    // Called at a negedge; returns at the negedge after the beat's posedge.
    task automatic beat(input int d, input logic we, input logic [3:0] nib);
        int n = 0;
        while (!req_ready[d] && n < 50) begin
            @(negedge clk);
            n++;
        end
        tests++;
        if (req_ready[d] !== 1'b1) begin
            fails++;
            $display("FAIL beat_ready dut%0d: req_ready=%b, required 1", d, req_ready[d]);
        end
        req_valid[d] = 1'b1;
        req_we       = we;
        req_nib      = nib;
        @(posedge clk);
        @(negedge clk);
        req_valid[d] = 1'b0;
        $display("[TB] dut%0d beat we=%b nib=%h", d, we, nib);
    endtask

    task automatic do_write(input int d, input logic [7:0] addr, input logic [7:0] data,
                            input int gap, output int lat, output int done_cnt);
        logic [3:0] nibs [4];
        nibs[0] = addr[7:4]; nibs[1] = addr[3:0]; nibs[2] = data[7:4]; nibs[3] = data[3:0];
        lat = -1;
        done_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            beat(d, 1'b1, nibs[i]);
            if (i < 3) repeat (gap) @(negedge clk);
        end
        for (int k = 0; k < 40; k++) begin
            if (wr_done[d]) begin
                done_cnt++;
                if (lat < 0) lat = k;
            end
            if (!busy[d] && k > 0) break;
            @(negedge clk);
        end
        $display("[TB] dut%0d write %h<=%h lat=%0d done=%0d", d, addr, data, lat, done_cnt);
    endtask

    task automatic do_read(input int d, input logic [7:0] addr, input int gap, input int hold,
                           output int lat, output logic [3:0] hi, output logic [3:0] lo,
                           output logic stable, output logic lo_valid, output logic busy_after);
        logic [3:0] first;
        rsp_ready[d] = 1'b0;
        lat = -1;
        stable = 1'b1;
        beat(d, 1'b0, addr[7:4]);
        repeat (gap) @(negedge clk);
        beat(d, 1'b0, addr[3:0]);
        for (int k = 0; k < 40; k++) begin
            if (rsp_valid[d]) begin
                lat = k;
                break;
            end
            @(negedge clk);
        end
        first = nib_of(d);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            if (!rsp_valid[d] || nib_of(d) !== first) stable = 1'b0;
        end
        hi = nib_of(d);
        rsp_ready[d] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        lo = nib_of(d);
        lo_valid = rsp_valid[d];
        @(posedge clk);
        @(negedge clk);
        rsp_ready[d] = 1'b0;
        busy_after = busy[d];
        $display("[TB] dut%0d read %h lat=%0d hi=%h lo=%h", d, addr, lat, hi, lo);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        tests++;
        if (req_ready !== 2'b11 || busy !== 2'b00 || rsp_valid !== 2'b00 || wr_done !== 2'b00) begin
            fails++;
            $display("FAIL reset_init: ready=%b busy=%b rsp_valid=%b wr_done=%b, required 11 00 00 00",
                     req_ready, busy, rsp_valid, wr_done);
        end
        beat(1, 1'b1, 4'h3);
        beat(1, 1'b1, 4'hC);
        tests++;
        if (busy[1] !== 1'b1) begin
            fails++;
            $display("FAIL reset_pre_busy: busy=%b, required 1", busy[1]);
        end
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        tests++;
        if (req_ready[1] !== 1'b1 || rsp_valid[1] !== 1'b0 || wr_done[1] !== 1'b0 ||
            busy[1] !== 1'b0 || rsp_nib1 !== 4'h0) begin
            fails++;
            $display("FAIL reset_mid: ready=%b rsp_valid=%b wr_done=%b busy=%b nib=%h, required 1 0 0 0 0",
                     req_ready[1], rsp_valid[1], wr_done[1], busy[1], rsp_nib1);
        end
        $display("[TB] reset checks done");
    endtask

    task automatic test_write_read();
        int lat, done_cnt;
        logic [3:0] hi, lo;
        logic stable, lo_valid, busy_after;
        do_write(1, 8'h3C, 8'hA5, 0, lat, done_cnt);
        tests++;
        if (lat != 2 || done_cnt != 1) begin
            fails++;
            $display("FAIL write_done: lat=%0d pulses=%0d, required lat=2 pulses=1", lat, done_cnt);
        end
        do_read(1, 8'h3C, 0, 0, lat, hi, lo, stable, lo_valid, busy_after);
        tests++;
        if (lat != 2) begin
            fails++;
            $display("FAIL read_latency: lat=%0d, required 2", lat);
        end
        tests++;
        if (hi !== 4'hA || lo !== 4'h5 || lo_valid !== 1'b1 || busy_after !== 1'b0) begin
            fails++;
            $display("FAIL read_data: hi=%h lo=%h lo_valid=%b busy=%b, required A 5 1 0",
                     hi, lo, lo_valid, busy_after);
        end
    endtask

    task automatic test_backpressure();
        int lat;
        logic [3:0] hi, lo;
        logic stable, lo_valid, busy_after;
        do_read(1, 8'h3C, 0, 5, lat, hi, lo, stable, lo_valid, busy_after);
        tests++;
        if (stable !== 1'b1 || hi !== 4'hA) begin
            fails++;
            $display("FAIL bp_hold: stable=%b hi=%h, required 1 A", stable, hi);
        end
        tests++;
        if (lo !== 4'h5 || lo_valid !== 1'b1 || busy_after !== 1'b0) begin
            fails++;
            $display("FAIL bp_release: lo=%h lo_valid=%b busy=%b, required 5 1 0", lo, lo_valid, busy_after);
        end
    endtask

    task automatic test_boundaries();
        int lat, done_cnt;
        logic [3:0] hi, lo;
        logic stable, lo_valid, busy_after;
        do_write(1, 8'h00, 8'h0F, 0, lat, done_cnt);
        do_write(1, 8'hFF, 8'hF0, 0, lat, done_cnt);
        do_read(1, 8'h00, 0, 0, lat, hi, lo, stable, lo_valid, busy_after);
        tests++;
        if ({hi, lo} !== 8'h0F) begin
            fails++;
            $display("FAIL bound_00: got %h, required 0f", {hi, lo});
        end
        do_read(1, 8'hFF, 0, 0, lat, hi, lo, stable, lo_valid, busy_after);
        tests++;
        if ({hi, lo} !== 8'hF0) begin
            fails++;
            $display("FAIL bound_ff: got %h, required f0", {hi, lo});
        end
    endtask

    task automatic test_rst_access();
        int lat;
        logic [3:0] hi, lo;
        logic stable, lo_valid, busy_after;
        logic seen_done = 1'b0;
        beat(1, 1'b1, 4'h3);
        beat(1, 1'b1, 4'hC);
        beat(1, 1'b1, 4'h7);
        beat(1, 1'b1, 4'h7);
        if (wr_done[1]) seen_done = 1'b1;
        @(negedge clk);
        if (wr_done[1]) seen_done = 1'b1;
        rst = 1'b1;
        repeat (2) begin
            @(negedge clk);
            if (wr_done[1]) seen_done = 1'b1;
        end
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (wr_done[1]) seen_done = 1'b1;
        end
        tests++;
        if (seen_done !== 1'b0 || busy[1] !== 1'b0) begin
            fails++;
            $display("FAIL rst_access: wr_done_seen=%b busy=%b, required 0 0", seen_done, busy[1]);
        end
        do_read(1, 8'h3C, 0, 0, lat, hi, lo, stable, lo_valid, busy_after);
        tests++;
        if ({hi, lo} !== 8'hA5) begin
            fails++;
            $display("FAIL rst_access_data: got %h, required a5", {hi, lo});
        end
    endtask

    task automatic test_wait0_gaps();
        int lat, done_cnt;
        logic [3:0] hi, lo;
        logic stable, lo_valid, busy_after;
        logic ign_ok = 1'b1;
        int n = 0;
        do_write(0, 8'h81, 8'h5A, 2, lat, done_cnt);
        tests++;
        if (lat != 1 || done_cnt != 1) begin
            fails++;
            $display("FAIL w0_write: lat=%0d pulses=%0d, required lat=1 pulses=1", lat, done_cnt);
        end
        do_read(0, 8'h81, 2, 0, lat, hi, lo, stable, lo_valid, busy_after);
        tests++;
        if (lat != 1 || {hi, lo} !== 8'h5A) begin
            fails++;
            $display("FAIL w0_read: lat=%0d data=%h, required lat=1 data=5a", lat, {hi, lo});
        end
        // Stray request beats while the response is pending must be ignored.
        rsp_ready[0] = 1'b0;
        beat(0, 1'b0, 4'h8);
        repeat (2) @(negedge clk);
        beat(0, 1'b0, 4'h1);
        while (!rsp_valid[0] && n < 40) begin
            @(negedge clk);
            n++;
        end
        req_valid[0] = 1'b1;
        req_we       = 1'b1;
        req_nib      = 4'hF;
        repeat (3) begin
            @(negedge clk);
            if (req_ready[0] !== 1'b0 || rsp_valid[0] !== 1'b1 || rsp_nib0 !== 4'h5) ign_ok = 1'b0;
        end
        req_valid[0] = 1'b0;
        rsp_ready[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        lo = rsp_nib0;
        @(posedge clk);
        @(negedge clk);
        rsp_ready[0] = 1'b0;
        tests++;
        if (ign_ok !== 1'b1 || lo !== 4'hA || busy[0] !== 1'b0) begin
            fails++;
            $display("FAIL w0_ignore: held_ok=%b lo=%h busy=%b, required 1 A 0", ign_ok, lo, busy[0]);
        end
        do_read(0, 8'h81, 0, 0, lat, hi, lo, stable, lo_valid, busy_after);
        tests++;
        if ({hi, lo} !== 8'h5A || busy_after !== 1'b0) begin
            fails++;
            $display("FAIL w0_reread: data=%h busy=%b, required 5a 0", {hi, lo}, busy_after);
        end
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = 2'b00;
        rsp_ready = 2'b00;
        req_we    = 1'b0;
        req_nib   = 4'h0;
        @(negedge clk);
        test_reset();
        test_write_read();
        test_backpressure();
        test_boundaries();
        test_rst_access();
        test_wait0_gaps();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
